// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared definitions for the matrix-vector datapath: default operand and
// counter widths, accumulator width derivation and the dot-product FSM
// state encoding. Used by the FIFOs, the dot-product engine and the top level.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mxv_pkg;

  localparam int MXV_DATA_WIDTH        = 8;
  localparam int MXV_NBITS_FOR_COUNTER = 6;

  // A signed DW x DW product needs 2*DW bits; summing up to 2^NB of them
  // needs NB more bits, so the accumulator can never overflow.
  function automatic int mxv_acc_width(input int data_width, input int nbits_for_counter);
    return 2 * data_width + nbits_for_counter;
  endfunction

  localparam int MXV_ACC_WIDTH = mxv_acc_width(MXV_DATA_WIDTH, MXV_NBITS_FOR_COUNTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mxv_dot_state_e;

endpackage

// File: rtl/mxv_mac_unit.sv
// -----------------------------------------------------------------------------
// mxv_mac_unit
// Registered signed multiply-accumulate: acc <= acc + sext(a*b) when en is
// high, acc <= 0 when clear is high (clear has priority).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the accumulator on the next edge
//   en          - add the product of a and b on the next edge
//   a, b        - signed operands, DATA_WIDTH bits
//   acc         - registered signed running sum, ACC_WIDTH bits
// -----------------------------------------------------------------------------
module mxv_mac_unit
  import mxv_pkg::*;
#(
  parameter int DATA_WIDTH = MXV_DATA_WIDTH,
  parameter int ACC_WIDTH  = MXV_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_d;

  assign prod     = a * b;
  assign prod_ext = {{EXT_WIDTH{prod[PROD_WIDTH-1]}}, prod};

  // NOTE: acc_d gets a default before any condition so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    acc_d = acc;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc + prod_ext;
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // always_ff samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_d;
    end
  end

endmodule

// File: rtl/mxv_dot_product_engine.sv
// -----------------------------------------------------------------------------
// mxv_dot_product_engine
// Pops paired matrix/vector elements from two FIFOs, multiplies them as signed
// values and accumulates the products over a programmable row length, then
// pulses result_valid for one cycle with the dot product on result.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   start, length            - begin a dot product of `length` elements (IDLE only)
//   matrix_empty/vector_empty- FIFO empty flags
//   matrix_data/vector_data  - FIFO read data, valid the cycle after a pop
//   pop_matrix/pop_vector    - paired FIFO pop enables (combinational)
//   busy                     - high in RUN and DONE
//   result, result_valid     - signed dot product and its one-cycle strobe
// -----------------------------------------------------------------------------
module mxv_dot_product_engine
  import mxv_pkg::*;
#(
  parameter int DATA_WIDTH        = MXV_DATA_WIDTH,
  parameter int NBITS_FOR_COUNTER = MXV_NBITS_FOR_COUNTER,
  parameter int ACC_WIDTH         = mxv_acc_width(DATA_WIDTH, NBITS_FOR_COUNTER)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NBITS_FOR_COUNTER-1:0] length,
  input  logic                         matrix_empty,
  input  logic                         vector_empty,
  input  logic [DATA_WIDTH-1:0]        matrix_data,
  input  logic [DATA_WIDTH-1:0]        vector_data,
  output logic                         pop_matrix,
  output logic                         pop_vector,
  output logic                         busy,
  output logic [ACC_WIDTH-1:0]         result,
  output logic                         result_valid
);

  localparam logic [NBITS_FOR_COUNTER-1:0] CNT_ONE = {{(NBITS_FOR_COUNTER-1){1'b0}}, 1'b1};

  mxv_dot_state_e                 state_q;
  logic [NBITS_FOR_COUNTER-1:0]   len_q;
  logic [NBITS_FOR_COUNTER-1:0]   issued_q;
  logic [NBITS_FOR_COUNTER-1:0]   consumed_q;
  logic [NBITS_FOR_COUNTER-1:0]   consumed_d;
  logic                           pop_d1_q;
  logic                           busy_q;
  logic                           result_valid_q;
  logic                           pop;
  logic                           acc_clear;
  logic signed [ACC_WIDTH-1:0]    acc;

  // Both FIFOs must have data so pops always stay paired; reset gates the
  // pop so no element is lost while the FSM is being cleared.
  assign pop = !reset && (state_q == RUN) && !matrix_empty && !vector_empty
               && (issued_q < len_q);

  assign acc_clear  = (state_q == IDLE) && start;
  assign consumed_d = consumed_q + CNT_ONE;

  mxv_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (pop_d1_q),
    .a     (matrix_data),
    .b     (vector_data),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      issued_q       <= '0;
      consumed_q     <= '0;
      pop_d1_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      // FIFO read data arrives one cycle after the pop.
      pop_d1_q       <= pop;
      result_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= length;
            issued_q   <= '0;
            consumed_q <= '0;
            busy_q     <= 1'b1;
            if (length == '0) begin
              state_q        <= DONE;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            issued_q <= issued_q + CNT_ONE;
          end
          if (pop_d1_q) begin
            consumed_q <= consumed_d;
            if (consumed_d == len_q) begin
              state_q        <= DONE;
              result_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pop_matrix   = pop;
  assign pop_vector   = pop;
  assign busy         = busy_q;
  // The accumulator is cleared only by an accepted start or reset, so once the
  // last product lands (entering DONE) it holds the dot product until the next
  // accepted start.
  assign result       = acc;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mxv_dot_product_engine.sv
module tb_mxv_dot_product_engine;

  localparam int DW = 8;
  localparam int NB = 6;
  localparam int AW = 2 * DW + NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] length = '0;
  logic          matrix_empty = 1'b1;
  logic          vector_empty = 1'b1;
  logic [DW-1:0] matrix_data = '0;
  logic [DW-1:0] vector_data = '0;
  logic          pop_matrix;
  logic          pop_vector;
  logic          busy;
  logic [AW-1:0] result;
  logic          result_valid;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] vq[$];
  logic [DW-1:0] tm, tv;
  int            sb[$];
  int            cyc = 0;
  int            pops_m = 0;
  int            pops_v = 0;
  int            pop_err = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  mxv_dot_product_engine #(
    .DATA_WIDTH        (DW),
    .NBITS_FOR_COUNTER (NB),
    .ACC_WIDTH         (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .matrix_empty (matrix_empty),
    .vector_empty (vector_empty),
    .matrix_data  (matrix_data),
    .vector_data  (vector_data),
    .pop_matrix   (pop_matrix),
    .pop_vector   (pop_vector),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // FIFO models: data appears the cycle after a pop; flags refresh away from
  // the rising edge so the DUT's combinational pop never races them.
  always begin
    @(posedge clk);
    cyc++;
    if (pop_matrix !== pop_vector) pop_err++;
    if (pop_matrix === 1'b1) begin
      if (mq.size() == 0) pop_err++;
      else begin
        tm = mq.pop_front();
        matrix_data <= tm;
        pops_m++;
      end
    end
    if (pop_vector === 1'b1) begin
      if (vq.size() == 0) pop_err++;
      else begin
        tv = vq.pop_front();
        vector_data <= tv;
        pops_v++;
      end
    end
    #1;
    matrix_empty = (mq.size() == 0);
    vector_empty = (vq.size() == 0);
    @(negedge clk);
    #1;
    matrix_empty = (mq.size() == 0);
    vector_empty = (vq.size() == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pair(input int m, input int v);
    mq.push_back(m[DW-1:0]);
    vq.push_back(v[DW-1:0]);
  endtask

  task automatic do_start(input int len, input bit hold, output int c0);
    @(negedge clk);
    start  = 1'b1;
    length = len[NB-1:0];
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    c0 = cyc;
  endtask

  // Waits for result_valid, reports its cycle number relative to the start
  // edge (cycle 1 follows that edge) and compares against the scoreboard.
  task automatic wait_result(input int c0, input int exp_cyc, input string name);
    int got;
    int exp_v;
    got = -1;
    for (int i = 0; i < 200 && got < 0; i++) begin
      @(negedge clk);
      #2;
      if (result_valid === 1'b1) got = cyc - c0 + 1;
    end
    exp_v = 0;
    if (sb.size() > 0) exp_v = sb.pop_front();
    n_tests++;
    if (got < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: no result_valid within 200 cycles", name);
      return;
    end
    n_tests++;
    if (got !== exp_cyc) begin
      n_fail++;
      $display("FAIL %s_latency: result_valid in cycle %0d, expected cycle %0d", name, got, exp_cyc);
    end
    n_tests++;
    if (int'($signed(result)) !== exp_v) begin
      n_fail++;
      $display("FAIL %s_result: got %0d, expected %0d", name, $signed(result), exp_v);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || int'($signed(result)) !== exp_v) begin
      n_fail++;
      $display("FAIL %s_after_done: valid=%b busy=%b result=%0d, expected valid=0 busy=0 result=%0d",
               name, result_valid, busy, $signed(result), exp_v);
    end
  endtask

  task automatic check_pops(input int p0, input int v0, input int e0, input int exp_n, input string name);
    n_tests++;
    if (pops_m - p0 !== exp_n || pops_v - v0 !== exp_n || pop_err !== e0) begin
      n_fail++;
      $display("FAIL %s_pops: matrix=%0d vector=%0d pairing_errors=%0d, expected %0d paired pops",
               name, pops_m - p0, pops_v - v0, pop_err - e0, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_tests++;
    if (pop_matrix !== 1'b0 || pop_vector !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pop: got %b/%b, expected 0/0", pop_matrix, pop_vector);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    n_tests++;
    if (result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %0h, expected 0", result);
    end
    n_tests++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, expected 0", result_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c0, p0, v0, e0;
    for (int i = 1; i <= 4; i++) push_pair(i, i + 4);
    sb.push_back(70);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(4, 1'b0, c0);
    @(negedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b1 || pop_matrix !== 1'b1 || pop_vector !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cycle1: busy=%b pop=%b/%b, expected 1 1/1", busy, pop_matrix, pop_vector);
    end
    wait_result(c0, 6, "basic");
    check_pops(p0, v0, e0, 4, "basic");
  endtask

  task automatic test_signed();
    int c0, p0, v0, e0;
    push_pair(-128, -128);
    push_pair(127, -128);
    push_pair(-1, -1);
    sb.push_back(129);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(3, 1'b0, c0);
    wait_result(c0, 5, "signed");
    check_pops(p0, v0, e0, 3, "signed");
  endtask

  task automatic test_reset_mid();
    int c0, p0, v0, e0, extra;
    for (int i = 1; i <= 8; i++) push_pair(i, i);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(8, 1'b0, c0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #2;
    n_tests++;
    if (pop_matrix !== 1'b0 || pop_vector !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pop: got %b/%b during reset, expected 0/0", pop_matrix, pop_vector);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b0 || result !== '0 || result_valid !== 1'b0 || pop_matrix !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b result=%0d valid=%b pop=%b, expected 0 0 0 0",
               busy, $signed(result), result_valid, pop_matrix);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (result_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d cycles with valid/busy after reset, expected 0", extra);
    end
    check_pops(p0, v0, e0, 2, "reset_mid");
    @(negedge clk);
    mq.delete();
    vq.delete();
    push_pair(2, 5);
    push_pair(3, 6);
    push_pair(4, 7);
    sb.push_back(56);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(3, 1'b0, c0);
    wait_result(c0, 5, "after_reset");
    check_pops(p0, v0, e0, 3, "after_reset");
  endtask

  task automatic test_stall();
    int c0, p0, v0, e0;
    push_pair(3, 2);
    mq.push_back(8'(-4));
    mq.push_back(8'(5));
    sb.push_back(-53);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(3, 1'b0, c0);
    @(negedge clk);
    #2;
    n_tests++;
    if (pop_matrix !== 1'b1 || pop_vector !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_cycle1_pop: got %b/%b, expected 1/1", pop_matrix, pop_vector);
    end
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      #2;
      n_tests++;
      if (pop_matrix !== 1'b0 || pop_vector !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d_pop: got %b/%b with vector empty, expected 0/0", k, pop_matrix, pop_vector);
      end
    end
    @(negedge clk);
    vq.push_back(8'(6));
    vq.push_back(8'(-7));
    #2;
    n_tests++;
    if (pop_matrix !== 1'b1 || pop_vector !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_refill_pop: got %b/%b, expected 1/1", pop_matrix, pop_vector);
    end
    wait_result(c0, 7, "stall");
    check_pops(p0, v0, e0, 3, "stall");
  endtask

  task automatic test_zero_len();
    int c0, p0, v0, e0;
    sb.push_back(0);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(0, 1'b0, c0);
    wait_result(c0, 1, "zero_len");
    check_pops(p0, v0, e0, 0, "zero_len");
  endtask

  task automatic test_start_ignored();
    int c0, p0, v0, e0, extra;
    push_pair(9, 4);
    push_pair(-3, 11);
    sb.push_back(3);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(2, 1'b0, c0);
    @(posedge clk);
    #1;
    start  = 1'b1;
    length = 6'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result(c0, 4, "start_ignored");
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (result_valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL start_ignored_restart: %0d cycles busy/valid after DONE, expected 0", extra);
    end
    check_pops(p0, v0, e0, 2, "start_ignored");
  endtask

  task automatic test_back_to_back();
    int c0, p0, v0, e0, e1, e2, m, v;
    e1 = 0;
    e2 = 0;
    for (int i = 0; i < 6; i++) begin
      m = int'($urandom_range(0, 255)) - 128;
      v = int'($urandom_range(0, 255)) - 128;
      push_pair(m, v);
      if (i < 3) e1 += m * v;
      else e2 += m * v;
    end
    sb.push_back(e1);
    sb.push_back(e2);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(3, 1'b1, c0);
    wait_result(c0, 5, "b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result(c0, 11, "b2b_second");
    check_pops(p0, v0, e0, 6, "b2b");
  endtask

  task automatic test_max_len();
    int c0, p0, v0, e0;
    for (int i = 0; i < 63; i++) push_pair(-128, -128);
    sb.push_back(1032192);
    p0 = pops_m; v0 = pops_v; e0 = pop_err;
    do_start(63, 1'b0, c0);
    wait_result(c0, 65, "max_len");
    check_pops(p0, v0, e0, 63, "max_len");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_reset_mid();
    test_stall();
    test_zero_len();
    test_start_ignored();
    test_back_to_back();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
